// File: rtl/circle_layer_mapper.sv
// rtl/circle_layer_mapper.sv - 3-stage renderer of N_OBJ circles over terrain/background with collision report
// Optional feature macro: CIRCLE_OUTLINE_EN (one-pixel black ring around each object).
module circle_layer_mapper #(
    parameter int          N_OBJ       = 4,
    parameter int          COORD_W     = 10,
    parameter int          TERRAIN_W   = 512,
    parameter logic [23:0] BG_RGB      = 24'h80A6FF,
    parameter logic [23:0] TERRAIN_RGB = 24'h009933,
    localparam int         IDX_W       = (N_OBJ > 1) ? $clog2(N_OBJ) : 1
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 frame_start,
    input  logic [COORD_W-1:0]   DrawX,
    input  logic [COORD_W-1:0]   DrawY,
    input  logic                 blank,
    input  logic [TERRAIN_W-1:0] terrain_data,
    input  logic                 wr_en,
    input  logic [IDX_W-1:0]     wr_idx,
    input  logic [COORD_W-1:0]   wr_x,
    input  logic [COORD_W-1:0]   wr_y,
    input  logic [COORD_W-1:0]   wr_r,
    input  logic [23:0]          wr_rgb,
    input  logic                 wr_vis,
    output logic [7:0]           Red,
    output logic [7:0]           Green,
    output logic [7:0]           Blue,
    output logic [N_OBJ-1:0]     hit_mask,
    output logic [N_OBJ-1:0]     coll_terrain,
    output logic                 coll_pair
);
    localparam int D2_W = 2 * COORD_W + 3;

    logic [COORD_W-1:0] sh_x [N_OBJ];
    logic [COORD_W-1:0] sh_y [N_OBJ];
    logic [COORD_W-1:0] sh_r [N_OBJ];
    logic [23:0]        sh_rgb [N_OBJ];
    logic [N_OBJ-1:0]   sh_vis;
    logic [COORD_W-1:0] ac_x [N_OBJ];
    logic [COORD_W-1:0] ac_y [N_OBJ];
    logic [COORD_W-1:0] ac_r [N_OBJ];
    logic [23:0]        ac_rgb [N_OBJ];
    logic [N_OBJ-1:0]   ac_vis;

    // Nonblocking commit copies the pre-write shadow when a write lands on the same edge.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < N_OBJ; i++) begin
                sh_x[i]   <= '0;
                sh_y[i]   <= '0;
                sh_r[i]   <= '0;
                sh_rgb[i] <= '0;
                ac_x[i]   <= '0;
                ac_y[i]   <= '0;
                ac_r[i]   <= '0;
                ac_rgb[i] <= '0;
            end
            sh_vis <= '0;
            ac_vis <= '0;
        end else begin
            if (frame_start) begin
                for (int i = 0; i < N_OBJ; i++) begin
                    ac_x[i]   <= sh_x[i];
                    ac_y[i]   <= sh_y[i];
                    ac_r[i]   <= sh_r[i];
                    ac_rgb[i] <= sh_rgb[i];
                end
                ac_vis <= sh_vis;
            end
            if (wr_en && (int'(wr_idx) < N_OBJ)) begin
                sh_x[wr_idx]   <= wr_x;
                sh_y[wr_idx]   <= wr_y;
                sh_r[wr_idx]   <= wr_r;
                sh_rgb[wr_idx] <= wr_rgb;
                sh_vis[wr_idx] <= wr_vis;
            end
        end
    end

    // Later stages read the active bank directly: it only changes at frame_start,
    // when everything in flight is a blanked pixel.
    logic signed [COORD_W:0] dx_c  [N_OBJ];
    logic signed [COORD_W:0] dy_c  [N_OBJ];
    logic signed [COORD_W:0] s1_dx [N_OBJ];
    logic signed [COORD_W:0] s1_dy [N_OBJ];
    logic [TERRAIN_W-1:0]    terr_row;
    logic                    s1_terr;
    logic                    s1_blank;

    assign terr_row = terrain_data >> DrawY;

    always_comb begin
        for (int i = 0; i < N_OBJ; i++) begin
            dx_c[i] = $signed({1'b0, DrawX}) - $signed({1'b0, ac_x[i]});
            dy_c[i] = $signed({1'b0, DrawY}) - $signed({1'b0, ac_y[i]});
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < N_OBJ; i++) begin
                s1_dx[i] <= '0;
                s1_dy[i] <= '0;
            end
            s1_terr  <= 1'b0;
            s1_blank <= 1'b0;
        end else begin
            for (int i = 0; i < N_OBJ; i++) begin
                s1_dx[i] <= dx_c[i];
                s1_dy[i] <= dy_c[i];
            end
            s1_terr  <= terr_row[0];
            s1_blank <= blank;
        end
    end

    logic signed [D2_W-1:0] dxe   [N_OBJ];
    logic signed [D2_W-1:0] dye   [N_OBJ];
    logic [D2_W-1:0]        d2_c  [N_OBJ];
    logic [D2_W-1:0]        r_ext [N_OBJ];
    logic [D2_W-1:0]        r2_c  [N_OBJ];
    logic [N_OBJ-1:0]       hit_c;
    logic [N_OBJ-1:0]       s2_hit;
    logic                   s2_terr;
    logic                   s2_blank;

    always_comb begin
        hit_c = '0;
        for (int i = 0; i < N_OBJ; i++) begin
            dxe[i]   = {{(D2_W-COORD_W-1){s1_dx[i][COORD_W]}}, s1_dx[i]};
            dye[i]   = {{(D2_W-COORD_W-1){s1_dy[i][COORD_W]}}, s1_dy[i]};
            d2_c[i]  = dxe[i] * dxe[i] + dye[i] * dye[i];
            r_ext[i] = {{(D2_W-COORD_W){1'b0}}, ac_r[i]};
            r2_c[i]  = r_ext[i] * r_ext[i];
            hit_c[i] = ac_vis[i] && (d2_c[i] <= r2_c[i]);
        end
    end

`ifdef CIRCLE_OUTLINE_EN
    logic [D2_W-1:0]  rm1    [N_OBJ];
    logic [D2_W-1:0]  rm1_sq [N_OBJ];
    logic [N_OBJ-1:0] ring_c;
    logic [N_OBJ-1:0] s2_ring;

    always_comb begin
        ring_c = '0;
        for (int i = 0; i < N_OBJ; i++) begin
            rm1[i]    = r_ext[i] - D2_W'(1);
            rm1_sq[i] = rm1[i] * rm1[i];
            ring_c[i] = (ac_r[i] != '0) && (d2_c[i] > rm1_sq[i]);
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) s2_ring <= '0;
        else          s2_ring <= ring_c;
    end
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s2_hit   <= '0;
            s2_terr  <= 1'b0;
            s2_blank <= 1'b0;
        end else begin
            s2_hit   <= hit_c;
            s2_terr  <= s1_terr;
            s2_blank <= s1_blank;
        end
    end

    logic [23:0]      sel_rgb;
    logic             multi_hit;
    logic [N_OBJ-1:0] ct_acc;
    logic             cp_acc;

    // Descending loop so the lowest-index hit is assigned last and wins.
    always_comb begin
        sel_rgb = s2_terr ? TERRAIN_RGB : BG_RGB;
        for (int i = N_OBJ - 1; i >= 0; i--) begin
            if (s2_hit[i]) begin
`ifdef CIRCLE_OUTLINE_EN
                sel_rgb = s2_ring[i] ? 24'h000000 : ac_rgb[i];
`else
                sel_rgb = ac_rgb[i];
`endif
            end
        end
    end

    assign multi_hit = (s2_hit & (s2_hit - N_OBJ'(1))) != '0;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            {Red, Green, Blue} <= '0;
            hit_mask           <= '0;
            coll_terrain       <= '0;
            coll_pair          <= 1'b0;
            ct_acc             <= '0;
            cp_acc             <= 1'b0;
        end else begin
            if (s2_blank) begin
                {Red, Green, Blue} <= sel_rgb;
                hit_mask           <= s2_hit;
            end else begin
                {Red, Green, Blue} <= '0;
                hit_mask           <= '0;
            end
            if (frame_start) begin
                coll_terrain <= ct_acc;
                coll_pair    <= cp_acc;
                ct_acc       <= '0;
                cp_acc       <= 1'b0;
            end else if (s2_blank) begin
                ct_acc <= ct_acc | (s2_hit & {N_OBJ{s2_terr}});
                cp_acc <= cp_acc | multi_hit;
            end
        end
    end
endmodule

// File: tb/tb_circle_layer_mapper.sv
// tb/tb_circle_layer_mapper.sv - bench for circle_layer_mapper with a per-pixel geometric reference model
module tb_circle_layer_mapper;
    localparam logic [23:0] BG = 24'h80A6FF;
    localparam logic [23:0] TR = 24'h009933;
`ifdef CIRCLE_OUTLINE_EN
    localparam logic [23:0] RIM  = 24'h000000;
    localparam logic [23:0] RIM2 = 24'h000000;
`else
    localparam logic [23:0] RIM  = 24'hCC3300;
    localparam logic [23:0] RIM2 = 24'h123456;
`endif

    logic         Clk, Reset_n, frame_start, blank, wr_en, wr_vis;
    logic [9:0]   DrawX, DrawY, wr_x, wr_y, wr_r;
    logic [511:0] terrain_data;
    logic [1:0]   wr_idx;
    logic [23:0]  wr_rgb;
    logic [7:0]   Red, Green, Blue;
    logic [3:0]   hit_mask, coll_terrain;
    logic         coll_pair;

    circle_layer_mapper dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start),
        .DrawX(DrawX), .DrawY(DrawY), .blank(blank), .terrain_data(terrain_data),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_x(wr_x), .wr_y(wr_y), .wr_r(wr_r),
        .wr_rgb(wr_rgb), .wr_vis(wr_vis),
        .Red(Red), .Green(Green), .Blue(Blue),
        .hit_mask(hit_mask), .coll_terrain(coll_terrain), .coll_pair(coll_pair)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;
    int seq   = 0;

    int          m_sh_x [4], m_sh_y [4], m_sh_r [4];
    bit          m_sh_vis [4];
    logic [23:0] m_sh_rgb [4];
    int          m_ac_x [4], m_ac_y [4], m_ac_r [4];
    bit          m_ac_vis [4];
    logic [23:0] m_ac_rgb [4];
    logic [3:0]  acc_ct, exp_ct;
    bit          acc_cp, exp_cp;

    typedef struct {
        int          id;
        logic [23:0] rgb;
        logic [3:0]  mask;
    } exp_t;
    exp_t q[$];

    typedef struct {
        int          x;
        int          y;
        bit          b;
        logic [23:0] rgb;
        logic [3:0]  mask;
    } vec_t;
    vec_t tbl[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_sh_x[i] = 0; m_sh_y[i] = 0; m_sh_r[i] = 0; m_sh_vis[i] = 0; m_sh_rgb[i] = '0;
            m_ac_x[i] = 0; m_ac_y[i] = 0; m_ac_r[i] = 0; m_ac_vis[i] = 0; m_ac_rgb[i] = '0;
        end
        acc_ct = '0; acc_cp = 0; exp_ct = '0; exp_cp = 0;
        q.delete();
    endtask

    // Colour of one pixel from circle geometry and the priority rules.
    task automatic model_pix(input int x, input int y, input bit b,
                             output logic [23:0] rgb, output logic [3:0] hits, output bit terr);
        int w, dx, dy, d2, r;
        hits = '0;
        w = -1; d2 = 0; r = 0;
        terr = (y < 512) ? terrain_data[y] : 1'b0;
        for (int i = 0; i < 4; i++) begin
            dx = x - m_ac_x[i];
            dy = y - m_ac_y[i];
            if (m_ac_vis[i] && (dx * dx + dy * dy <= m_ac_r[i] * m_ac_r[i])) begin
                hits[i] = 1'b1;
                if (w < 0) begin
                    w  = i;
                    d2 = dx * dx + dy * dy;
                    r  = m_ac_r[i];
                end
            end
        end
        rgb = b ? (terr ? TR : BG) : 24'h0;
        if (b && w >= 0) begin
            rgb = m_ac_rgb[w];
`ifdef CIRCLE_OUTLINE_EN
            if (r > 0 && d2 > (r - 1) * (r - 1)) rgb = 24'h0;
`endif
        end
    endtask

    task automatic cycle(input int x, input int y, input bit b,
                         input bit use_tbl, input logic [23:0] trgb, input logic [3:0] tmask);
        exp_t        e;
        logic [23:0] rgb;
        logic [3:0]  hits;
        bit          terr, fs;
        DrawX = 10'(x); DrawY = 10'(y); blank = b;
        model_pix(x, y, b, rgb, hits, terr);
        e.id   = seq++;
        e.rgb  = use_tbl ? trgb : rgb;
        e.mask = use_tbl ? tmask : (b ? hits : 4'b0);
        if (b) begin
            acc_ct |= hits & {4{terr}};
            if ($countones(hits) >= 2) acc_cp = 1;
        end
        q.push_back(e);
        fs = frame_start;
        if (fs) begin
            exp_ct = acc_ct; exp_cp = acc_cp; acc_ct = '0; acc_cp = 0;
            for (int i = 0; i < 4; i++) begin
                m_ac_x[i] = m_sh_x[i]; m_ac_y[i] = m_sh_y[i]; m_ac_r[i] = m_sh_r[i];
                m_ac_vis[i] = m_sh_vis[i]; m_ac_rgb[i] = m_sh_rgb[i];
            end
        end
        if (wr_en) begin
            m_sh_x[wr_idx] = int'(wr_x); m_sh_y[wr_idx] = int'(wr_y); m_sh_r[wr_idx] = int'(wr_r);
            m_sh_vis[wr_idx] = wr_vis; m_sh_rgb[wr_idx] = wr_rgb;
        end
        @(posedge Clk);
        #1;
        frame_start = 1'b0;
        wr_en = 1'b0;
        if (q.size() == 3) begin
            e = q.pop_front();
            check($sformatf("rgb#%0d", e.id), {8'h0, Red, Green, Blue}, {8'h0, e.rgb});
            check($sformatf("mask#%0d", e.id), {28'h0, hit_mask}, {28'h0, e.mask});
        end
        if (fs) begin
            check("coll_terrain", {28'h0, coll_terrain}, {28'h0, exp_ct});
            check("coll_pair", {31'h0, coll_pair}, {31'h0, exp_cp});
        end
    endtask

    task automatic pix(input int x, input int y, input bit b);
        cycle(x, y, b, 1'b0, 24'h0, 4'h0);
    endtask

    task automatic tpix(input int x, input int y, input bit b, input logic [23:0] rgb, input logic [3:0] mask);
        cycle(x, y, b, 1'b1, rgb, mask);
    endtask

    task automatic commit();
        repeat (3) pix(0, 0, 1'b0);
        frame_start = 1'b1;
        pix(0, 0, 1'b0);
    endtask

    task automatic wr_obj(input int idx, input int x, input int y, input int r,
                          input logic [23:0] rgb, input bit vis);
        wr_idx = 2'(idx); wr_x = 10'(x); wr_y = 10'(y); wr_r = 10'(r);
        wr_rgb = rgb; wr_vis = vis; wr_en = 1'b1;
        pix(0, 0, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int x, y, o;
        tbl[0] = '{89, 100, 1'b1, BG, 4'b0000};
        tbl[1] = '{90, 100, 1'b1, RIM, 4'b0001};
        tbl[2] = '{91, 100, 1'b1, 24'hCC3300, 4'b0001};
        tbl[3] = '{100, 100, 1'b1, 24'hCC3300, 4'b0001};
        tbl[4] = '{110, 100, 1'b1, RIM, 4'b0001};
        tbl[5] = '{111, 100, 1'b1, BG, 4'b0000};
        tbl[6] = '{100, 89, 1'b1, BG, 4'b0000};
        tbl[7] = '{100, 90, 1'b1, RIM, 4'b0001};
        tbl[8] = '{100, 100, 1'b0, 24'h0, 4'b0000};

        Reset_n = 1'b0; frame_start = 1'b0; blank = 1'b0; wr_en = 1'b0; wr_vis = 1'b0;
        DrawX = '0; DrawY = '0; wr_x = '0; wr_y = '0; wr_r = '0; wr_idx = '0; wr_rgb = '0;
        terrain_data = '0;
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        check("reset_rgb", {8'h0, Red, Green, Blue}, 32'h0);
        check("reset_mask", {28'h0, hit_mask}, 32'h0);
        check("reset_ct", {28'h0, coll_terrain}, 32'h0);
        check("reset_cp", {31'h0, coll_pair}, 32'h0);
        Reset_n = 1'b1;

        // single object, row/column edges
        wr_obj(0, 100, 100, 10, 24'hCC3300, 1'b1);
        commit();
        for (int i = 0; i < 9; i++) tpix(tbl[i].x, tbl[i].y, tbl[i].b, tbl[i].rgb, tbl[i].mask);
        for (int i = 85; i <= 115; i++) pix(i, 100, 1'b1);

        // overlap and pair collision
        wr_obj(1, 105, 100, 10, 24'h00FF00, 1'b1);
        commit();
        tpix(103, 100, 1'b1, 24'hCC3300, 4'b0011);
        tpix(112, 100, 1'b1, 24'h00FF00, 4'b0010);
        for (int i = 90; i <= 120; i++) pix(i, 100, 1'b1);
        commit();
        check("pair_set", {31'h0, coll_pair}, 32'h1);
        commit();
        check("pair_clear", {31'h0, coll_pair}, 32'h0);

        // terrain collision, blanked pixel does not count
        terrain_data[300] = 1'b1;
        wr_obj(2, 50, 295, 5, 24'h123456, 1'b1);
        commit();
        tpix(50, 300, 1'b1, RIM2, 4'b0100);
        tpix(51, 300, 1'b1, TR, 4'b0000);
        tpix(50, 301, 1'b1, BG, 4'b0000);
        commit();
        check("terr_set", {28'h0, coll_terrain}, 32'h4);
        tpix(50, 300, 1'b0, 24'h0, 4'b0000);
        commit();
        check("terr_blank", {28'h0, coll_terrain}, 32'h0);

        // write in the same cycle as frame_start
        wr_obj(3, 100, 400, 3, 24'hABCDEF, 1'b1);
        commit();
        repeat (3) pix(0, 0, 1'b0);
        wr_idx = 2'd3; wr_x = 10'd200; wr_y = 10'd400; wr_r = 10'd3;
        wr_rgb = 24'hABCDEF; wr_vis = 1'b1; wr_en = 1'b1; frame_start = 1'b1;
        pix(0, 0, 1'b0);
        tpix(100, 400, 1'b1, 24'hABCDEF, 4'b1000);
        tpix(200, 400, 1'b1, BG, 4'b0000);
        commit();
        tpix(100, 400, 1'b1, BG, 4'b0000);
        tpix(200, 400, 1'b1, 24'hABCDEF, 4'b1000);

        // rim pixels and a radius-0 object
        terrain_data = '0;
        for (int i = 0; i < 4; i++) wr_obj(i, 0, 0, 0, 24'h0, 1'b0);
        wr_obj(0, 100, 100, 10, 24'hCC3300, 1'b1);
        wr_obj(1, 300, 300, 0, 24'h5A5A5A, 1'b1);
        commit();
        tpix(110, 100, 1'b1, RIM, 4'b0001);
        tpix(109, 100, 1'b1, 24'hCC3300, 4'b0001);
        tpix(300, 300, 1'b1, 24'h5A5A5A, 4'b0010);
        tpix(301, 300, 1'b1, BG, 4'b0000);
        tpix(300, 299, 1'b1, BG, 4'b0000);

        // randomized scenes
        for (int it = 0; it < 5; it++) begin
            for (int i = 0; i < 512; i++) terrain_data[i] = ($urandom_range(0, 5) == 0);
            for (int k = 0; k < 4; k++)
                wr_obj(k, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                       int'($urandom_range(0, 40)), 24'($urandom), $urandom_range(0, 3) != 0);
            commit();
            for (int k = 0; k < 150; k++) begin
                o = int'($urandom_range(0, 3));
                x = m_ac_x[o] + int'($urandom_range(0, 100)) - 50;
                y = m_ac_y[o] + int'($urandom_range(0, 100)) - 50;
                if (x < 0) x = 0;
                if (x > 1023) x = 1023;
                if (y < 0) y = 0;
                if (y > 1023) y = 1023;
                pix(x, y, $urandom_range(0, 4) != 0);
            end
            commit();
        end

        // asynchronous reset in the middle of a frame
        terrain_data = '0;
        wr_obj(0, 100, 100, 10, 24'hCC3300, 1'b1);
        wr_obj(1, 105, 100, 10, 24'h00FF00, 1'b1);
        commit();
        for (int i = 98; i <= 106; i++) pix(i, 100, 1'b1);
        Reset_n = 1'b0;
        model_reset();
        #2;
        check("midrst_rgb", {8'h0, Red, Green, Blue}, 32'h0);
        check("midrst_mask", {28'h0, hit_mask}, 32'h0);
        check("midrst_ct", {28'h0, coll_terrain}, 32'h0);
        check("midrst_cp", {31'h0, coll_pair}, 32'h0);
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        for (int i = 95; i <= 105; i++) tpix(i, 100, 1'b1, BG, 4'b0000);
        commit();
        for (int i = 95; i <= 105; i++) pix(i, 100, 1'b1);
        repeat (3) pix(0, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
